fp_norm_round: RTL and testbench
================================

FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL have parameter BIAS, default 127, the exponent bias used for packing and range checks.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream adder/subtractor core offers a raw result.
REQ-005 SHALL have port in_ready  output  1  block accepts the offered result this cycle.
REQ-006 SHALL have port in_sign  input  1  sign of the raw result.
REQ-007 SHALL have port in_exp  input  10  signed two's-complement biased exponent for a hidden bit at in_mant[26].
REQ-008 SHALL have port in_mant  input  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-009 SHALL have port in_nan / in_inf  input  1 each  special result, in_nan dominant.
REQ-010 SHALL have port out_valid  output  1  packed result available.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the result.
REQ-012 SHALL have port out_result  output  32  IEEE-754 single-precision result.
REQ-013 SHALL have port out_flags  output  4  {overflow, underflow, inexact, zero}.

Function
REQ-014 SHALL be a two-stage pipeline: S1 normalizes, S2 rounds and packs; accept-to-out_valid latency is exactly 2 cycles with no stall.
REQ-015 SHALL compute adv2 = !s2_valid | out_ready, adv1 = !s1_valid | adv2, in_ready = adv1, giving one result per cycle at full throughput.
REQ-016 SHALL hold out_result/out_flags stable while out_valid & !out_ready, and never drop, duplicate or reorder results.
REQ-017 S1 SHALL, when in_mant[27]=1, shift right 1 (OR the shifted-out bit into sticky) and increment exponent.
REQ-018 S1 SHALL, otherwise, left-shift by the leading-zero count so bit 26 is set, and subtract that count from the exponent.
REQ-019 S2 SHALL round to nearest even: increment if G & (R | S | LSB); a rounding carry out of bit 26 SHALL shift right 1 and increment the exponent.
REQ-020 SHALL report inexact when any of G, R, S is set after normalization.
REQ-021 SHALL output +0 (0x00000000, zero flag set) for an all-zero mantissa with no special input.
REQ-022 SHALL output 0x7FC00000 for in_nan and {in_sign, 0xFF, 0} for in_inf, with all flags clear.
REQ-023 SHALL, when the final exponent is >= 255, output {sign, 0xFF, 0} with overflow and inexact set.
REQ-024 SHALL treat a final exponent <= 0 per REQ-029/REQ-030.

Reset
REQ-025 SHALL clear s1_valid and s2_valid on rst, giving out_valid=0, out_result=0 and out_flags=0.
REQ-026 SHALL hold in_ready=0 during rst, and reset SHALL take priority over simultaneous in_valid or out_ready.
REQ-027 SHALL discard in-flight results when rst asserts mid-operation, producing no output for them.

Configuration
REQ-028 SHALL compile subnormal support only when macro FP_DENORM_EN is defined.
REQ-029 With FP_DENORM_EN: SHALL right-shift the mantissa by (1 - exp), saturating at 27 with sticky OR, then round; exponent field 0, or 1 if rounding reaches bit 26; underflow set when the result is tiny and inexact.
REQ-030 Without FP_DENORM_EN: SHALL flush to {sign, 31'b0}, setting zero, plus underflow and inexact when the mantissa is nonzero.

Structure
REQ-031 SHALL take the flag bit indices, the canonical NaN constant, the mantissa field positions and the S1-to-S2 struct typedef from the shared package fp_pkg.
REQ-032 SHALL instantiate one sub-module, fp_lzc (28-bit leading-zero counter, combinational), in S1.

Verification
REQ-033 SHALL check: exp=128, mant=0x2000000 -> 0x3F800000, flags 0 (3.0-2.0).
REQ-034 SHALL check: exp=128, mant=0x8000000 -> 0x40800000 (2.5+1.5 carry case).
REQ-035 SHALL check: mant=0, sign=1 -> 0x00000000, zero flag set.
REQ-036 SHALL check: exp=127, mant=0x7FFFFFC (all fraction ones, G=1, R=S=0) -> 0x40000000, inexact set.
REQ-037 SHALL check: exp=254, mant=0x8000000 -> 0x7F800000, overflow and inexact set; exp=-5 with and without FP_DENORM_EN -> subnormal vs 0x00000000 with underflow.
REQ-038 SHALL check backpressure: 4 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts and all 4 emerge in order; rst mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the FP normalize/round datapath: flag indices,
// raw-mantissa field positions, canonical NaN and the S1-to-S2 pipeline word.
package fp_pkg;

  localparam int FLAG_OVF  = 3;
  localparam int FLAG_UNF  = 2;
  localparam int FLAG_INX  = 1;
  localparam int FLAG_ZERO = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  localparam int MANT_W       = 28;
  localparam int MANT_CARRY   = 27;
  localparam int MANT_HIDDEN  = 26;
  localparam int MANT_FRAC_HI = 25;
  localparam int MANT_FRAC_LO = 3;
  localparam int MANT_GUARD   = 2;
  localparam int MANT_ROUND   = 1;
  localparam int MANT_STICKY  = 0;

  // Wide enough for in_exp +1 or minus a full 26-bit normalization shift
  localparam int EXP_W = 12;

  typedef struct packed {
    logic                    sign;
    logic                    nan;
    logic                    inf;
    logic                    zero;
    logic signed [EXP_W-1:0] exp;
    logic [MANT_HIDDEN:0]    mant;
  } s1_s2_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational 28-bit leading-zero counter; returns 28 for an all-zero input.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] in_vec,
  output logic [4:0]        lz_cnt
);

  always_comb begin
    lz_cnt = 5'd28;
    for (int i = 0; i < MANT_W; i++) begin
      if (in_vec[i]) lz_cnt = 5'(MANT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize (S1) and round-to-nearest-even/pack (S2) back end for
// an FP add/sub core. Subnormal outputs are produced only with FP_DENORM_EN.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int BIAS = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic signed [9:0] in_exp,
  input  logic [27:0]       in_mant,
  input  logic              in_nan,
  input  logic              in_inf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [3:0]        out_flags
);

  localparam logic signed [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic              adv1, adv2;
  s1_s2_t            data_p1_q, data_p1_d;
  logic [31:0]       res_p2_q, res_p2_d;
  logic [3:0]        flags_p2_q, flags_p2_d;
  logic [4:0]        lz_cnt;
  logic [4:0]        shl_amt;
  logic [MANT_W-1:0] mant_shl;

  logic signed [EXP_W-1:0] e_n, e_r;
  logic [MANT_HIDDEN:0]    m_r;
  logic [24:0]             sum;
  logic [22:0]             frac;
  logic                    inx;

  // Returns {carry, hidden, fraction[22:0]} after round-to-nearest-even
  function automatic logic [24:0] round_rne(input logic [MANT_HIDDEN:0] m);
    logic inc;
    inc = m[MANT_GUARD] & (m[MANT_ROUND] | m[MANT_STICKY] | m[MANT_FRAC_LO]);
    return {1'b0, m[MANT_HIDDEN:MANT_FRAC_LO]} + {24'b0, inc};
  endfunction

`ifdef FP_DENORM_EN
  // Right shift by (1 - e), saturated at 27, collecting lost bits into sticky
  function automatic logic [MANT_HIDDEN:0] denorm_shift(
    input logic [MANT_HIDDEN:0]    m,
    input logic signed [EXP_W-1:0] e
  );
    logic [53:0] wide;
    logic [4:0]  sh;
    if (e <= -12'sd26) sh = 5'd27;
    else               sh = 5'(12'sd1 - e);
    wide = {m, 27'b0} >> sh;
    return {wide[53:28], wide[27] | (|wide[26:0])};
  endfunction
`endif

  assign adv2     = !s2_valid_q | out_ready;
  assign adv1     = !s1_valid_q | adv2;
  assign in_ready = adv1 & !rst;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (adv2) s2_valid_d = s1_valid_q;
    if (adv1) s1_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // ---- S1: normalize so the leading one sits at the hidden-bit position ----
  fp_lzc u_lzc (
    .in_vec (in_mant),
    .lz_cnt (lz_cnt)
  );

  always_comb begin
    shl_amt          = lz_cnt - 5'd1;
    mant_shl         = in_mant << shl_amt;
    data_p1_d.sign   = in_sign;
    data_p1_d.nan    = in_nan;
    data_p1_d.inf    = in_inf;
    data_p1_d.zero   = (in_mant == '0);
    data_p1_d.exp    = EXP_W'(in_exp);
    data_p1_d.mant   = mant_shl[MANT_HIDDEN:0];
    if (in_mant[MANT_CARRY]) begin
      data_p1_d.mant = {in_mant[MANT_CARRY:2], in_mant[1] | in_mant[0]};
      data_p1_d.exp  = EXP_W'(in_exp) + 12'sd1;
    end else if (in_mant != '0) begin
      data_p1_d.exp  = EXP_W'(in_exp) - $signed({7'b0, shl_amt});
    end
  end

  always_ff @(posedge clk) begin
    if (adv1) data_p1_q <= data_p1_d;
  end

  // ---- S2: round, range-check and pack ----
  always_comb begin
    res_p2_d   = '0;
    flags_p2_d = '0;
    e_n        = $signed(data_p1_q.exp);
    e_r        = e_n;
    m_r        = data_p1_q.mant;
    sum        = round_rne(m_r);
    inx        = |m_r[MANT_GUARD:MANT_STICKY];
    frac       = sum[22:0];
    if (data_p1_q.nan) begin
      res_p2_d = CANON_NAN;
    end else if (data_p1_q.inf) begin
      res_p2_d = {data_p1_q.sign, 8'hFF, 23'b0};
    end else if (data_p1_q.zero) begin
      flags_p2_d[FLAG_ZERO] = 1'b1;
    end else if (e_n >= 12'sd1) begin
      if (sum[24]) begin
        e_r  = e_n + 12'sd1;
        frac = sum[23:1];
      end
      if (e_r >= EXP_MAX) begin
        res_p2_d             = {data_p1_q.sign, 8'hFF, 23'b0};
        flags_p2_d[FLAG_OVF] = 1'b1;
        flags_p2_d[FLAG_INX] = 1'b1;
      end else begin
        res_p2_d             = {data_p1_q.sign, e_r[7:0], frac};
        flags_p2_d[FLAG_INX] = inx;
      end
    end else begin
`ifdef FP_DENORM_EN
      m_r                   = denorm_shift(data_p1_q.mant, e_n);
      sum                   = round_rne(m_r);
      inx                   = |m_r[MANT_GUARD:MANT_STICKY];
      res_p2_d              = {data_p1_q.sign, 7'b0, sum[23], sum[22:0]};
      flags_p2_d[FLAG_INX]  = inx;
      flags_p2_d[FLAG_UNF]  = inx;
      flags_p2_d[FLAG_ZERO] = (sum[23:0] == '0);
`else
      res_p2_d              = {data_p1_q.sign, 31'b0};
      flags_p2_d[FLAG_ZERO] = 1'b1;
      flags_p2_d[FLAG_UNF]  = |data_p1_q.mant;
      flags_p2_d[FLAG_INX]  = |data_p1_q.mant;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (adv2) begin
      res_p2_q   <= res_p2_d;
      flags_p2_q <= flags_p2_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_valid_q ? res_p2_q : '0;
  assign out_flags  = s2_valid_q ? flags_p2_q : '0;

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: expected words are queued at acceptance
// and compared in order as the DUT hands results downstream.
module tb_fp_norm_round;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [27:0]       in_mant;
  logic              in_nan;
  logic              in_inf;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [3:0]        out_flags;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out    = 0;
  logic [35:0] sb[$];

  always #5 clk = ~clk;

  fp_norm_round #(.BIAS(127)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_nan     (in_nan),
    .in_inf     (in_inf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send(input logic s, input logic signed [9:0] e, input logic [27:0] m,
                      input logic nan, input logic inf,
                      input logic [31:0] r, input logic [3:0] f);
    int guard;
    @(negedge clk);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_nan   = nan;
    in_inf   = inf;
    in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_eq("in_ready_accept", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back({r, f});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: in-order scoreboard compare plus stall stability
  initial begin
    logic        held;
    logic [31:0] last_r;
    logic [3:0]  last_f;
    logic [35:0] e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        held = 1'b0;
      end else if (out_valid) begin
        if (held) begin
          check_eq("hold_result", out_result, last_r);
          check_eq("hold_flags", 32'(out_flags), 32'(last_f));
        end
        if (out_ready) begin
          held = 1'b0;
          if (sb.size() == 0) begin
            check_eq("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            check_eq($sformatf("result#%0d", n_out), out_result, e[35:4]);
            check_eq($sformatf("flags#%0d", n_out), 32'(out_flags), 32'(e[3:0]));
            n_out++;
          end
        end else begin
          held   = 1'b1;
          last_r = out_result;
          last_f = out_flags;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_nan = 1'b0; in_inf = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_result", out_result, 32'd0);
    check_eq("rst_out_flags", 32'(out_flags), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Accept-to-out_valid latency of two cycles
    send(1'b0, 10'sd128, 28'h2000000, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
    idle();
    #1;
    check_eq("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check_eq("lat_cycle2", 32'(out_valid), 32'd1);
    drain();

    // Function vectors at full throughput
    send(1'b0, 10'sd128, 28'h8000000, 1'b0, 1'b0, 32'h40800000, 4'b0000);
    send(1'b1, 10'sd50,  28'h0000000, 1'b0, 1'b0, 32'h00000000, 4'b0001);
    send(1'b0, 10'sd127, 28'h7FFFFFC, 1'b0, 1'b0, 32'h40000000, 4'b0010);
    send(1'b0, 10'sd254, 28'h8000000, 1'b0, 1'b0, 32'h7F800000, 4'b1010);
    send(1'b0, 10'sd254, 28'h7FFFFFC, 1'b0, 1'b0, 32'h7F800000, 4'b1010);
    send(1'b0, 10'sd254, 28'h4000000, 1'b0, 1'b0, 32'h7F000000, 4'b0000);
    send(1'b0, 10'sd1,   28'h4000000, 1'b0, 1'b0, 32'h00800000, 4'b0000);
`ifdef FP_DENORM_EN
    send(1'b0, -10'sd5,  28'h4000000, 1'b0, 1'b0, 32'h00020000, 4'b0000);
    send(1'b0, 10'sd0,   28'h4000000, 1'b0, 1'b0, 32'h00400000, 4'b0000);
`else
    send(1'b0, -10'sd5,  28'h4000000, 1'b0, 1'b0, 32'h00000000, 4'b0111);
    send(1'b0, 10'sd0,   28'h4000000, 1'b0, 1'b0, 32'h00000000, 4'b0111);
`endif
    send(1'b0, 10'sd7,   28'h4000000, 1'b1, 1'b1, 32'h7FC00000, 4'b0000);
    send(1'b1, 10'sd7,   28'h4000000, 1'b0, 1'b1, 32'hFF800000, 4'b0000);
    send(1'b0, 10'sd127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, 4'b0010);
    send(1'b0, 10'sd127, 28'h400000C, 1'b0, 1'b0, 32'h3F800002, 4'b0010);
    send(1'b1, 10'sd130, 28'h4000000, 1'b0, 1'b0, 32'hC1000000, 4'b0000);
    send(1'b0, 10'sd127, 28'h8000001, 1'b0, 1'b0, 32'h40000000, 4'b0010);
    send(1'b0, 10'sd140, 28'h0000008, 1'b0, 1'b0, 32'h3A800000, 4'b0000);
    idle();
    drain();

    // Backpressure: two accepts fill the pipe, then in_ready drops
    @(negedge clk);
    out_ready = 1'b0;
    send(1'b0, 10'sd128, 28'h2000000, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
    send(1'b0, 10'sd128, 28'h8000000, 1'b0, 1'b0, 32'h40800000, 4'b0000);
    @(negedge clk);
    #1;
    check_eq("bp_in_ready_low", 32'(in_ready), 32'd0);
    check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    fork
      begin
        send(1'b1, 10'sd130, 28'h4000000, 1'b0, 1'b0, 32'hC1000000, 4'b0000);
        send(1'b0, 10'sd127, 28'h400000C, 1'b0, 1'b0, 32'h3F800002, 4'b0010);
      end
      begin
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle();
    drain();

    // Reset mid-stream discards in-flight results
    send(1'b0, 10'sd128, 28'h2000000, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
    send(1'b0, 10'sd128, 28'h8000000, 1'b0, 1'b0, 32'h40800000, 4'b0000);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    check_eq("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid_out_result", out_result, 32'd0);
    check_eq("rst_mid_out_flags", 32'(out_flags), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_mid_discarded", 32'(out_valid), 32'd0);

    send(1'b0, 10'sd254, 28'h4000000, 1'b0, 1'b0, 32'h7F000000, 4'b0000);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
